// File: rtl/blk_arbiter_if.sv
// Block-source / link-FIFO bundle seen by blk_arbiter.
// master = arbiter side, slave = sources plus link FIFO side.
interface blk_arbiter_if #(
  parameter int NSRC  = 4,
  parameter int SBITS = 3
);
  logic [NSRC-1:0]    give;
  logic [NSRC-1:0]    have;
  logic [16*NSRC-1:0] din;
  logic [15:0]        dout;
  logic               dvalid;
  logic               dready;
  logic [SBITS-1:0]   cur_src;
  logic               busy;
  logic               err;

  modport master (
    output give, dout, dvalid, cur_src, busy, err,
    input  have, din, dready
  );

  modport slave (
    input  give, dout, dvalid, cur_src, busy, err,
    output have, din, dready
  );
endinterface

// File: rtl/blk_arbiter.sv
// Round-robin block arbiter: pulls CW-framed blocks from NSRC sources, forwards each unbroken.
// Optional macro ARB_CWCHECK_EN: drop non-CW words seen in HEAD and raise sticky err.
//
// state | meaning
// HEAD  | scanning sources; the next accepted word is a control word
// BODY  | forwarding the cnt remaining words of the current block
module blk_arbiter #(
  parameter int NSRC  = 4,
  parameter int SBITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  blk_arbiter_if.master bus
);

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t           state;
  logic [SBITS-1:0] sel;
  logic [8:0]       cnt;
  logic [15:0]      dout_q;
  logic             dvalid_q;
  logic             busy_q;

  logic [NSRC-1:0]  give_c;
  logic [15:0]      word;
  logic             xfer;
  logic             cw_ok;
  logic [SBITS-1:0] sel_next;

  // give is held low during reset so no source sees a request before sel is defined
  always_comb begin
    give_c = '0;
    word   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SBITS'(i)) begin
        give_c[i] = bus.dready & rst_n;
        word      = bus.din[16*i +: 16];
      end
    end
  end

  assign xfer     = |(give_c & bus.have);
  assign sel_next = (sel == SBITS'(NSRC-1)) ? '0 : sel + 1'b1;

`ifdef ARB_CWCHECK_EN
  assign cw_ok = word[15];
`else
  assign cw_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HEAD;
      sel      <= '0;
      cnt      <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      case (state)
        HEAD: begin
          if (xfer) begin
            if (cw_ok) begin
              dout_q   <= word;
              dvalid_q <= 1'b1;
              cnt      <= word[8:0];
              if (word[8:0] == 9'd0) begin
                sel <= sel_next;
              end else begin
                state  <= BODY;
                busy_q <= 1'b1;
              end
            end
          end else if (bus.dready) begin
            sel <= sel_next;
          end
        end
        BODY: begin
          if (xfer) begin
            dout_q   <= word;
            dvalid_q <= 1'b1;
            cnt      <= cnt - 9'd1;
            if (cnt == 9'd1) begin
              sel    <= sel_next;
              state  <= HEAD;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= HEAD;
      endcase
    end
  end

`ifdef ARB_CWCHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == HEAD && xfer && !word[15]) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.give    = give_c;
  assign bus.dout    = dout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.busy    = busy_q;
  assign bus.cur_src = sel;

endmodule

// File: tb/tb_blk_arbiter.sv
// Bench for blk_arbiter: per-source word queues, round-robin block-order reference model.
module tb_blk_arbiter;
  localparam int NSRC  = 4;
  localparam int SBITS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blk_arbiter_if #(.NSRC(NSRC), .SBITS(SBITS)) bus();
  blk_arbiter #(.NSRC(NSRC), .SBITS(SBITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  logic [15:0]      src_q [NSRC][$];
  logic [15:0]      exp_q [$];
  int               rem [NSRC];
  int               cyc, pops, nout, first_cyc, last_cyc;
  logic [SBITS-1:0] last_src;
  bit               rnd;
  int               stall_kind, stall_at, stall_len, stall_src;
  bit               stall_done;
  int               dlow_left, hstall_left;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit is_cw(input logic [15:0] w);
`ifdef ARB_CWCHECK_EN
    return w[15];
`else
    return 1'b1;
`endif
  endfunction

  task automatic add_block(input int s, input int len);
    src_q[s].push_back(16'h8000 | 16'(len));
    for (int k = 1; k <= len; k++) src_q[s].push_back(16'($urandom));
  endtask

  // Expected stream: from source 0, each non-empty source in turn yields one whole block.
  task automatic build_expected();
    logic [15:0] cp [NSRC][$];
    logic [15:0] w;
    int p = 0;
    bit any;
    for (int i = 0; i < NSRC; i++) cp[i] = src_q[i];
    exp_q.delete();
    forever begin
      any = 1'b0;
      for (int i = 0; i < NSRC; i++) if (cp[i].size() > 0) any = 1'b1;
      if (!any) break;
      if (cp[p].size() > 0) begin
        w = cp[p].pop_front();
        while (!is_cw(w) && cp[p].size() > 0) w = cp[p].pop_front();
        if (is_cw(w)) begin
          exp_q.push_back(w);
          for (int k = 0; k < int'(w[8:0]); k++)
            if (cp[p].size() > 0) exp_q.push_back(cp[p].pop_front());
        end
      end
      p = (p + 1) % NSRC;
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < NSRC; i++) begin
      src_q[i].delete();
      rem[i] = 0;
    end
    exp_q.delete();
    pops = 0; nout = 0; first_cyc = -1; last_cyc = -1; last_src = '0;
    rnd = 1'b0; stall_kind = 0; stall_done = 1'b0; dlow_left = 0; hstall_left = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dready = 1'b0; bus.have = '0; bus.din = '0;
    clear_state();
    repeat (2) @(negedge clk);
    chk("rst_give", 32'(bus.give), 0);
    chk("rst_dvalid", 32'(bus.dvalid), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cur_src", 32'(bus.cur_src), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    logic [15:0] w;
    logic [NSRC-1:0] hv;
    logic [16*NSRC-1:0] dv;
    logic dr;
    @(negedge clk);
    cyc++;
    if (bus.dvalid) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 1);
      else begin
        w = exp_q.pop_front();
        chk("dout", 32'(bus.dout), 32'(w));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nout++;
        last_src = bus.cur_src;
      end
    end
    chk("give_onehot", 32'($countones(bus.give) <= 1), 1);
    if (!bus.dready) begin
      chk("give_dready_low", 32'(bus.give), 0);
      chk("dvalid_dready_low", 32'(bus.dvalid), 0);
    end
    if (stall_kind != 0 && !stall_done && pops == stall_at) begin
      stall_done = 1'b1;
      if (stall_kind == 1) dlow_left = stall_len;
      else hstall_left = stall_len;
    end
    dr = 1'b1;
    if (dlow_left > 0) begin
      dr = 1'b0;
      dlow_left--;
    end else if (rnd) dr = ($urandom_range(0, 4) != 0);
    hv = '0; dv = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_q[i].size() > 0) begin
        hv[i] = 1'b1;
        if (rnd && rem[i] != 0) hv[i] = ($urandom_range(0, 3) != 0);
        if (hstall_left > 0 && i == stall_src) hv[i] = 1'b0;
        dv[16*i +: 16] = src_q[i][0];
      end
    end
    bus.dready = dr; bus.have = hv; bus.din = dv;
    #1;
    if (hstall_left > 0) begin
      chk("hold_sel", 32'(bus.cur_src), 32'(stall_src));
      chk("hold_busy", 32'(bus.busy), 1);
      chk("give_only_src", 32'(bus.give & ~(NSRC'(1) << stall_src)), 0);
      hstall_left--;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (bus.give[i] && bus.have[i]) begin
        w = src_q[i].pop_front();
        if (rem[i] == 0) begin
          if (is_cw(w)) rem[i] = int'(w[8:0]);
        end else rem[i]--;
        pops++;
      end
    end
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    bit pending;
    forever begin
      pending = (exp_q.size() > 0);
      for (int i = 0; i < NSRC; i++) if (src_q[i].size() > 0) pending = 1'b1;
      if (!pending || n >= max_cyc) break;
      cycle();
      n++;
    end
    chk("stream_done", 32'(exp_q.size()), 0);
  endtask

  initial begin
    cyc = 0;
    bus.dready = 1'b0; bus.have = '0; bus.din = '0;

    // single block from src2, idle elsewhere
    do_reset();
    src_q[2].push_back(16'h8003);
    for (int k = 1; k <= 3; k++) src_q[2].push_back(16'(k));
    build_expected();
    run(100);
    chk("t1_nwords", 32'(nout), 4);
    chk("t1_consecutive", 32'(last_cyc - first_cyc + 1), 4);
    chk("t1_next_src", 32'(last_src), 3);

    // back-to-back blocks from src0 and src1
    do_reset();
    add_block(0, 1);
    add_block(1, 1);
    build_expected();
    run(100);
    chk("t2_nwords", 32'(nout), 4);
    chk("t2_consecutive", 32'(last_cyc - first_cyc + 1), 4);

    // dready low for 5 clocks mid-block
    do_reset();
    add_block(0, 4);
    add_block(3, 2);
    stall_kind = 1; stall_at = 2; stall_len = 5;
    build_expected();
    run(100);
    chk("t3_nwords", 32'(nout), 8);

    // have[1] drops for 3 clocks mid-block while src2 also waits
    do_reset();
    add_block(1, 5);
    add_block(2, 2);
    stall_kind = 2; stall_src = 1; stall_at = 3; stall_len = 3;
    build_expected();
    run(100);
    chk("t4_nwords", 32'(nout), 9);

    // L=0 block from src3 wraps selection to src0
    do_reset();
    add_block(3, 0);
    build_expected();
    run(100);
    chk("t5_nwords", 32'(nout), 1);
    chk("t5_wrap", 32'(last_src), 0);

    // asynchronous reset in the middle of an L=10 block
    do_reset();
    add_block(0, 10);
    build_expected();
    repeat (5) cycle();
    chk("t6_busy_before", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_dvalid", 32'(bus.dvalid), 0);
    chk("t6_async_dout", 32'(bus.dout), 0);
    chk("t6_async_busy", 32'(bus.busy), 0);
    chk("t6_async_cur_src", 32'(bus.cur_src), 0);
    chk("t6_async_give", 32'(bus.give), 0);
    do_reset();
    add_block(1, 1);
    add_block(0, 2);
    build_expected();
    run(100);
    chk("t6_restart_nwords", 32'(nout), 5);

`ifdef ARB_CWCHECK_EN
    do_reset();
    src_q[0].push_back(16'h1234);
    src_q[0].push_back(16'h8001);
    src_q[0].push_back(16'h0005);
    build_expected();
    run(100);
    chk("cw_nwords", 32'(nout), 2);
    chk("cw_err", 32'(bus.err), 1);
`endif

    // randomized traffic with dready and mid-block have stalls
    for (int it = 0; it < 4; it++) begin
      do_reset();
      rnd = 1'b1;
      for (int s = 0; s < NSRC; s++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++)
          add_block(s, ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 7));
      end
      if (it == 0) add_block(1, 511);
      build_expected();
      run(8000);
      chk("rnd_err_quiet", 32'(bus.err), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
